// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the RAM access controller: size codes, error codes, FSM states
// and the request legality check.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_SIZE    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } memState_e;

    // Only the two low address bits matter for alignment.
    function automatic logic [1:0] accessError(input logic [1:0] sz, input logic [1:0] lowAddr);
        case (sz)
            SZ_BYTE: return ERR_NONE;
            SZ_HALF: return lowAddr[0] ? ERR_ALIGN : ERR_NONE;
            SZ_WORD: return (lowAddr != 2'b00) ? ERR_ALIGN : ERR_NONE;
            default: return ERR_SIZE;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Load data formatter: keeps the accessed byte/halfword of the RAM read word and
// zero- or sign-extends it, discarding the RAM's stale upper bits.
module load_formatter
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        signLd,
    input  logic [31:0] dataOut,
    output logic [31:0] result
);

    always_comb begin
        result = dataOut;
        case (size)
            SZ_BYTE: result = {{24{signLd & dataOut[7]}}, dataOut[7:0]};
            SZ_HALF: result = {{16{signLd & dataOut[15]}}, dataOut[15:0]};
            default: result = dataOut;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer in front of the 512x8 RAM level handshake.
// Optional WAIT timeout abort is compiled in with MEMCTRL_TIMEOUT_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [8:0]  addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        sign_ld,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [31:0] rdata,
    output logic        memFuncActive,
    output logic        readWrite,
    output logic [8:0]  address,
    output logic [31:0] dataIn,
    output logic [1:0]  dataSize,
    input  logic        memFuncComplete,
    input  logic [31:0] dataOut
);

    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    memState_e   state, stateNext;
    logic [1:0]  errReg, errNext, reqErr;
    logic [31:0] rdataReg, fmtData;
    logic        signLdReg;
    logic        accept, captureLoad, timeoutHit;

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] waitCnt;

    assign timeoutHit = ((waitCnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES)) && !memFuncComplete;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            waitCnt <= '0;
        else if (state == ST_ISSUE)
            waitCnt <= '0;
        else if (state == ST_WAIT)
            waitCnt <= waitCnt + CNT_W'(1);
    end
`else
    assign timeoutHit = 1'b0;
`endif

    load_formatter uFormatter (
        .size    (dataSize),
        .signLd  (signLdReg),
        .dataOut (dataOut),
        .result  (fmtData)
    );

    assign reqErr = accessError(size, addr[1:0]);

    always_comb begin
        stateNext   = state;
        errNext     = errReg;
        accept      = 1'b0;
        captureLoad = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    errNext = reqErr;
                    // Rejected requests never touch the RAM handshake.
                    stateNext = (reqErr != ERR_NONE) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: stateNext = ST_WAIT;
            ST_WAIT: begin
                if (memFuncComplete) begin
                    captureLoad = !readWrite;
                    errNext     = ERR_NONE;
                    stateNext   = ST_DONE;
                end else if (timeoutHit) begin
                    errNext   = ERR_TIMEOUT;
                    stateNext = ST_DONE;
                end
            end
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            errReg    <= ERR_NONE;
            rdataReg  <= '0;
            readWrite <= 1'b0;
            address   <= '0;
            dataIn    <= '0;
            dataSize  <= SZ_BYTE;
            signLdReg <= 1'b0;
        end else begin
            state  <= stateNext;
            errReg <= errNext;
            if (accept) begin
                readWrite <= we;
                address   <= addr;
                dataIn    <= wdata;
                dataSize  <= size;
                signLdReg <= sign_ld;
            end
            if (captureLoad)
                rdataReg <= fmtData;
        end
    end

    // Decoded from the state register so reset drops the RAM request asynchronously.
    assign memFuncActive = (state == ST_ISSUE) || (state == ST_WAIT);
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);
    assign err           = errReg;
    assign rdata         = rdataReg;

endmodule
